// File: rtl/instr_mem_pkg.sv
// Shared types and helpers for the instruction-memory responder.
// This file defines the response record and the address-window check.
package instr_mem_pkg;

    typedef struct packed {
        logic        valid;
        logic        err;
        logic [31:0] data;
    } imem_resp_t;

    localparam logic [31:0] IMEM_ERR_DATA = 32'h0;

    // The limit is 33 bits wide so that a window ending exactly at 4 GiB still compares correctly.
    function automatic logic addr_in_range(input logic [31:0] addr,
                                           input logic [31:0] base,
                                           input logic [32:0] limit);
        return (addr >= base) && ({1'b0, addr} < limit);
    endfunction

endpackage

// File: rtl/instr_mem_responder_pipe.sv
// Fixed-latency response pipe. Each stage carries a valid bit and a payload.
// Payload moves forward only with a valid entry, so the output data and error
// hold their last value between responses.
module mem_resp_pipe
    import instr_mem_pkg::*;
#(
    parameter int LATENCY = 1
) (
    input  logic       clk,
    input  logic       rstn,
    input  imem_resp_t resp_in,
    output imem_resp_t resp_out
);

    imem_resp_t stage [LATENCY];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < LATENCY; i++) begin
                stage[i] <= '0;
            end
        end else begin
            stage[0].valid <= resp_in.valid;
            if (resp_in.valid) begin
                stage[0].err  <= resp_in.err;
                stage[0].data <= resp_in.data;
            end
            for (int i = 1; i < LATENCY; i++) begin
                stage[i].valid <= stage[i-1].valid;
                if (stage[i-1].valid) begin
                    stage[i].err  <= stage[i-1].err;
                    stage[i].data <= stage[i-1].data;
                end
            end
        end
    end

    assign resp_out = stage[LATENCY-1];

endmodule

// File: rtl/instr_mem_responder.sv
// This is the memory-side end of the instruction fetch bus.
// It contains a word-addressed RAM, a fixed response latency and a cap on outstanding requests.
module instr_mem_responder
    import instr_mem_pkg::*;
#(
    parameter int          MEM_WORDS = 4096,
    parameter logic [31:0] BASE_ADDR = 32'h0,
    parameter int          NUM_REQS  = 2,
    parameter int          LATENCY   = 1,
    parameter string       INIT_FILE = ""
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        instr_req_i,
    output logic        instr_gnt_o,
    input  logic [31:0] instr_addr_i,
    output logic [31:0] instr_rdata_o,
    output logic        instr_err_o,
    output logic        instr_rvalid_o,
    input  logic        gnt_block_i,
    input  logic        load_we_i,
    input  logic [31:0] load_addr_i,
    input  logic [31:0] load_data_i
);

    localparam int          IDX_W      = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam int          CNT_W      = $clog2(NUM_REQS + 1);
    localparam logic [32:0] ADDR_LIMIT = {1'b0, BASE_ADDR} + (33'(MEM_WORDS) << 2);

    if (LATENCY < 1)             begin : g_bad_latency  $error("LATENCY must be >= 1");        end
    if (NUM_REQS < 1)            begin : g_bad_num_reqs $error("NUM_REQS must be >= 1");       end
    if (MEM_WORDS < 1)           begin : g_bad_words    $error("MEM_WORDS must be >= 1");      end
    if (BASE_ADDR[1:0] != 2'b00) begin : g_bad_base     $error("BASE_ADDR must be word aligned"); end

    logic [31:0]      mem [MEM_WORDS];
    logic [CNT_W-1:0] outstanding;
    logic             accept;
    logic             retire;
    logic             fetch_err;
    logic             load_ok;
    logic [IDX_W-1:0] fetch_idx;
    logic [IDX_W-1:0] load_idx;
    imem_resp_t       resp_in;
    imem_resp_t       resp_out;

    // A response leaving the pipe frees a slot in the same cycle, so the requester can be
    // granted at the cap.
    assign retire      = resp_out.valid;
    assign instr_gnt_o = instr_req_i & ~gnt_block_i &
                         ((outstanding < CNT_W'(NUM_REQS)) | retire);
    assign accept      = instr_req_i & instr_gnt_o;

    assign fetch_err = !addr_in_range(instr_addr_i, BASE_ADDR, ADDR_LIMIT);
    assign fetch_idx = IDX_W'((instr_addr_i - BASE_ADDR) >> 2);
    assign load_ok   = load_we_i && addr_in_range(load_addr_i, BASE_ADDR, ADDR_LIMIT);
    assign load_idx  = IDX_W'((load_addr_i - BASE_ADDR) >> 2);

    // The array is read combinationally in the accept cycle. A loader write landing on the
    // same edge is therefore not visible to that fetch.
    always_comb begin
        resp_in.valid = accept;
        resp_in.err   = fetch_err;
        resp_in.data  = IMEM_ERR_DATA;
        if (!fetch_err) begin
            resp_in.data = mem[fetch_idx];
        end
    end

    always_ff @(posedge clk) begin
        if (load_ok) begin
            mem[load_idx] <= load_data_i;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            outstanding <= '0;
        end else begin
            case ({accept, retire})
                2'b10:   outstanding <= outstanding + CNT_W'(1);
                2'b01:   outstanding <= outstanding - CNT_W'(1);
                default: outstanding <= outstanding;
            endcase
        end
    end

    mem_resp_pipe #(
        .LATENCY (LATENCY)
    ) u_resp_pipe (
        .clk      (clk),
        .rstn     (rstn),
        .resp_in  (resp_in),
        .resp_out (resp_out)
    );

    assign instr_rvalid_o = resp_out.valid;
    assign instr_err_o    = resp_out.err;
    assign instr_rdata_o  = resp_out.data;

    assert property (@(posedge clk) disable iff (!rstn) !(retire && outstanding == '0));
    assert property (@(posedge clk) disable iff (!rstn) outstanding <= CNT_W'(NUM_REQS));

endmodule
